// File: rtl/gdsp_pkg.sv
// Shared constants, state type and width helper for the gdsp 16-QAM TX datapath.
package gdsp_pkg;

  localparam int SPS             = 4;
  localparam int BITS_PER_SYM    = 4;
  localparam int NUM_TAPS        = 5;
  localparam int NOISE_MAG_WIDTH = 8;
  localparam int SAMPLE_DIV      = 27;
  localparam int FLUSH_SAMPLES   = NUM_TAPS - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } tx_sched_state_t;

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gdsp_strobe_div.sv
// Free-running 0..DIV-1 divider with a tick at count 0; held at 0 while run is low.
module gdsp_strobe_div import gdsp_pkg::*; #(
  parameter int DIV = gdsp_pkg::SAMPLE_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [cnt_w(DIV)-1:0] cnt,
  output logic                  tick,
  output logic                  wrap
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == '0);
  assign wrap = run && (cnt == LAST);

endmodule

// File: rtl/tx_symbol_scheduler.sv
// TX sequencer: sample strobe, SPS phase, per-symbol PRBS fetch, FIR flush on stop,
// and symbol-aligned noise magnitude updates.
module tx_symbol_scheduler import gdsp_pkg::*; #(
  parameter int SAMPLE_DIV    = gdsp_pkg::SAMPLE_DIV,
  parameter int SPS           = gdsp_pkg::SPS,
  parameter int BITS_PER_SYM  = gdsp_pkg::BITS_PER_SYM,
  parameter int FLUSH_SAMPLES = gdsp_pkg::FLUSH_SAMPLES,
  parameter int NOISE_MAG_W   = gdsp_pkg::NOISE_MAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  output logic                    bit_req_o,
  input  logic                    bit_i,
  output logic [BITS_PER_SYM-1:0] sym_bits_o,
  output logic                    sample_tick_o,
  output logic                    sym_tick_o,
  output logic [cnt_w(SPS)-1:0]   phase_o,
  output logic                    zero_stuff_o,
  input  logic [NOISE_MAG_W-1:0]  noise_mag_i,
  input  logic                    noise_mag_wr_i,
  output logic [NOISE_MAG_W-1:0]  noise_mag_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int DW = cnt_w(SAMPLE_DIV);
  localparam int PW = cnt_w(SPS);
  localparam int FW = cnt_w(BITS_PER_SYM);
  localparam int XW = cnt_w(FLUSH_SAMPLES);
  localparam logic [DW-1:0] WIN_FIRST  = DW'(SAMPLE_DIV - BITS_PER_SYM);
  localparam logic [PW-1:0] PH_LAST    = PW'(SPS - 1);
  localparam logic [FW-1:0] FILL_LAST  = FW'(BITS_PER_SYM - 1);
  localparam logic [XW-1:0] FLUSH_LAST = XW'(FLUSH_SAMPLES - 1);

  if (SAMPLE_DIV < BITS_PER_SYM || SPS < 1) begin : g_param_check
    $error("tx_symbol_scheduler: requires SAMPLE_DIV >= BITS_PER_SYM and SPS >= 1");
  end

  tx_sched_state_t         state_q, state_d;
  logic [DW-1:0]           div_cnt;
  logic                    div_tick, div_wrap, div_run;
  logic [FW-1:0]           fill_cnt;
  logic [XW-1:0]           drain_cnt;
  logic [BITS_PER_SYM-1:0] sreg;
  logic                    stop_pend;
  logic [NOISE_MAG_W-1:0]  noise_shadow;
  logic                    noise_pend, noise_apply;
  logic                    in_window, win_first, sym_end, stop_now, fetch;

  function automatic logic [BITS_PER_SYM-1:0] shift_in(input logic [BITS_PER_SYM-1:0] s,
                                                       input logic b);
    return BITS_PER_SYM'({s, b});
  endfunction

  assign div_run = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  gdsp_strobe_div #(.DIV(SAMPLE_DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .run  (div_run),
    .cnt  (div_cnt),
    .tick (div_tick),
    .wrap (div_wrap)
  );

  // enable_i is only looked at on the first window cycle; later cycles follow that decision.
  always_comb begin
    in_window = (state_q == ST_RUN) && (phase_o == PH_LAST) && (div_cnt >= WIN_FIRST);
    win_first = in_window && (div_cnt == WIN_FIRST);
    sym_end   = (state_q == ST_RUN) && div_wrap && (phase_o == PH_LAST);
    stop_now  = stop_pend || (win_first && !enable_i);
    fetch     = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_FILL;
      ST_FILL: begin
        fetch = 1'b1;
        if (fill_cnt == FILL_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        fetch = in_window && (win_first ? enable_i : !stop_pend);
        if (sym_end && stop_now) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (div_wrap && (drain_cnt == FLUSH_LAST)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bit_req_o     = fetch;
  assign sample_tick_o = div_tick;
  assign sym_tick_o    = div_tick && (state_q == ST_RUN) && (phase_o == '0);
  assign zero_stuff_o  = (state_q == ST_DRAIN) || ((state_q == ST_RUN) && (phase_o != '0));
  assign busy_o        = (state_q != ST_IDLE);
  assign noise_apply   = noise_pend && ((state_q == ST_IDLE) || sym_tick_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_o    <= '0;
      fill_cnt   <= '0;
      drain_cnt  <= '0;
      stop_pend  <= 1'b0;
      done_o     <= 1'b0;
      sym_bits_o <= '0;
    end else begin
      state_q  <= state_d;
      done_o   <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      fill_cnt <= (state_q == ST_FILL) ? fill_cnt + 1'b1 : '0;
      if (!div_run) begin
        phase_o <= '0;
      end else if (div_wrap) begin
        phase_o <= (phase_o == PH_LAST) ? '0 : phase_o + 1'b1;
      end
      if (state_q != ST_DRAIN) begin
        drain_cnt <= '0;
      end else if (div_wrap) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
      if ((state_q != ST_RUN) || sym_end) begin
        stop_pend <= 1'b0;
      end else if (win_first && !enable_i) begin
        stop_pend <= 1'b1;
      end
      // The last fetched bit goes straight into the symbol register.
      if (fetch && ((state_q == ST_FILL) ? (fill_cnt == FILL_LAST) : div_wrap)) begin
        sym_bits_o <= shift_in(sreg, bit_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fetch) sreg <= shift_in(sreg, bit_i);
  end

  // A write landing on an apply edge waits for the following one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_mag_o  <= '0;
      noise_shadow <= '0;
      noise_pend   <= 1'b0;
    end else if (noise_apply) begin
      noise_mag_o <= noise_shadow;
      noise_pend  <= noise_mag_wr_i;
      if (noise_mag_wr_i) noise_shadow <= noise_mag_i;
    end else if (noise_mag_wr_i) begin
      noise_shadow <= noise_mag_i;
      if (state_q == ST_IDLE) begin
        noise_mag_o <= noise_mag_i;
      end else begin
        noise_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Randomized bench for tx_symbol_scheduler against a cycle-offset timeline model.
module tb_tx_symbol_scheduler;

  localparam int DIV    = 8;
  localparam int NSPS   = 4;
  localparam int NBITS  = 4;
  localparam int NFLUSH = 4;
  localparam int SYM    = DIV * NSPS;       // clk cycles per symbol
  localparam int RUN0   = 1 + NBITS;        // first RUN cycle after enable at cycle 0
  localparam int WIN    = SYM - NBITS;      // fetch window start offset inside a symbol
  localparam int DRN    = NFLUSH * DIV;     // drain length in cycles
  localparam int NEVER  = 1000;

  typedef struct packed {
    logic       req;
    logic       stick;
    logic       ytick;
    logic       zs;
    logic       busy;
    logic       done;
    logic [1:0] ph;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i;
  logic       bit_req_o;
  logic       bit_i;
  logic [3:0] sym_bits_o;
  logic       sample_tick_o;
  logic       sym_tick_o;
  logic [1:0] phase_o;
  logic       zero_stuff_o;
  logic [7:0] noise_mag_i;
  logic       noise_mag_wr_i;
  logic [7:0] noise_mag_o;
  logic       busy_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  tx_symbol_scheduler #(
    .SAMPLE_DIV(DIV), .SPS(NSPS), .BITS_PER_SYM(NBITS), .FLUSH_SAMPLES(NFLUSH), .NOISE_MAG_W(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .bit_req_o      (bit_req_o),
    .bit_i          (bit_i),
    .sym_bits_o     (sym_bits_o),
    .sample_tick_o  (sample_tick_o),
    .sym_tick_o     (sym_tick_o),
    .phase_o        (phase_o),
    .zero_stuff_o   (zero_stuff_o),
    .noise_mag_i    (noise_mag_i),
    .noise_mag_wr_i (noise_mag_wr_i),
    .noise_mag_o    (noise_mag_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Expected control outputs c cycles after enable was first seen in IDLE; symbol k's
  // fetch window sees enable low (k = NEVER means it never stops).
  function automatic ctl_t model(input int c, input int k);
    ctl_t e;
    int   o;
    e = '0;
    if (c >= 1 && c < RUN0) begin
      e.req  = 1'b1;
      e.busy = 1'b1;
    end else if (c >= RUN0) begin
      o = c - RUN0;
      if (o < SYM * (k + 1) + DRN) begin
        e.busy  = 1'b1;
        e.stick = (o % DIV == 0);
        e.ph    = 2'((o / DIV) % NSPS);
        if (o < SYM * (k + 1)) begin
          e.ytick = (o % SYM == 0);
          e.zs    = (e.ph != 2'd0);
          e.req   = (o % SYM >= WIN) && (o / SYM < k);
        end else begin
          e.zs = 1'b1;
        end
      end else begin
        e.done = (o == SYM * (k + 1) + DRN);
      end
    end
    return e;
  endfunction

  function automatic ctl_t observe();
    ctl_t v;
    v.req   = bit_req_o;
    v.stick = sample_tick_o;
    v.ytick = sym_tick_o;
    v.zs    = zero_stuff_o;
    v.busy  = busy_o;
    v.done  = done_o;
    v.ph    = phase_o;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    enable_i       = 1'b0;
    bit_i          = 1'b0;
    noise_mag_wr_i = 1'b0;
    noise_mag_i    = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t o;
    do_reset();
    #1;
    o = observe();
    checks++;
    if (o !== ctl_t'(0)) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", o, ctl_t'(0));
    end
    checks++;
    if (sym_bits_o !== 4'h0 || noise_mag_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got sym=%h noise=%h exp sym=0 noise=00", sym_bits_o, noise_mag_o);
    end
    enable_i       = 1'b1;
    noise_mag_wr_i = 1'b1;
    noise_mag_i    = 8'h55;
    bit_i          = 1'b1;
    for (int c = 1; c <= RUN0 + 2 * DIV + 3; c++) begin
      tick();
      noise_mag_wr_i = 1'b0;
    end
    #1;
    checks++;
    if (busy_o !== 1'b1 || noise_mag_o !== 8'h55 || sym_bits_o !== 4'hf) begin
      failures++;
      $display("FAIL reset_pre got busy=%b noise=%h sym=%h exp busy=1 noise=55 sym=f",
               busy_o, noise_mag_o, sym_bits_o);
    end
    rst = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== ctl_t'(0)) begin
      failures++;
      $display("FAIL reset_mid_ctrl got=%b exp=%b", o, ctl_t'(0));
    end
    checks++;
    if (sym_bits_o !== 4'h0 || noise_mag_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_data got sym=%h noise=%h exp sym=0 noise=00", sym_bits_o, noise_mag_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    enable_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      o = observe();
      checks++;
      if (o !== ctl_t'(0)) begin
        failures++;
        $display("FAIL reset_after c=%0d got=%b exp=%b", c, o, ctl_t'(0));
      end
      tick();
    end
  endtask

  task automatic test_start();
    ctl_t       e, o;
    logic [3:0] pat, acc, nxt, exp_sym;
    int         nacc;
    pat = 4'b1011; acc = '0; nxt = '0; exp_sym = '0; nacc = 0;
    do_reset();
    for (int c = 0; c <= RUN0 + 3 * SYM + 3; c++) begin
      e = model(c, NEVER);
      enable_i = 1'b1;
      if ((c >= 1 && c < RUN0) || (c >= RUN0 && (c - RUN0) % SYM > WIN))
        enable_i = 1'($urandom_range(0, 1));
      bit_i = (c >= 1 && c < RUN0) ? pat[RUN0 - 1 - c] : 1'($urandom_range(0, 1));
      #1;
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL start_ctrl c=%0d got=%b exp=%b", c, o, e);
      end
      checks++;
      if (sym_bits_o !== exp_sym) begin
        failures++;
        $display("FAIL start_sym c=%0d got=%h exp=%h", c, sym_bits_o, exp_sym);
      end
      if (e.req) begin
        acc = {acc[2:0], bit_i};
        nacc++;
        if (nacc == NBITS) begin
          nxt  = acc;
          nacc = 0;
        end
      end
      tick();
      exp_sym = nxt;
    end
  endtask

  task automatic test_stop();
    ctl_t       e, o;
    logic [3:0] acc, nxt, exp_sym;
    int         nacc, k, drop, ndone, nsym;
    acc = '0; nxt = '0; exp_sym = '0; nacc = 0; ndone = 0; nsym = 0;
    k    = $urandom_range(0, 1);
    drop = RUN0 + SYM * k + $urandom_range(1, WIN - 1);
    do_reset();
    for (int c = 0; c <= RUN0 + SYM * (k + 1) + DRN + 4; c++) begin
      e        = model(c, k);
      enable_i = (c < drop);
      bit_i    = 1'($urandom_range(0, 1));
      #1;
      o = observe();
      if (done_o === 1'b1) ndone++;
      if (sym_tick_o === 1'b1) nsym++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stop_ctrl k=%0d c=%0d got=%b exp=%b", k, c, o, e);
      end
      checks++;
      if (sym_bits_o !== exp_sym) begin
        failures++;
        $display("FAIL stop_sym c=%0d got=%h exp=%h", c, sym_bits_o, exp_sym);
      end
      if (e.req) begin
        acc = {acc[2:0], bit_i};
        nacc++;
        if (nacc == NBITS) begin
          nxt  = acc;
          nacc = 0;
        end
      end
      tick();
      exp_sym = nxt;
    end
    checks++;
    if (ndone != 1 || nsym != k + 1) begin
      failures++;
      $display("FAIL stop_counts got done=%0d sym_ticks=%0d exp done=1 sym_ticks=%0d", ndone, nsym, k + 1);
    end
  endtask

  task automatic test_drop_mid_window();
    ctl_t e, o;
    int   drop, nreq;
    nreq = 0;
    drop = RUN0 + WIN + $urandom_range(1, NBITS - 1);
    do_reset();
    for (int c = 0; c <= RUN0 + 2 * SYM + DRN + 4; c++) begin
      e        = model(c, 1);
      enable_i = (c < drop);
      bit_i    = 1'($urandom_range(0, 1));
      #1;
      o = observe();
      if (bit_req_o === 1'b1) nreq++;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midwin_ctrl c=%0d got=%b exp=%b", c, o, e);
      end
      tick();
    end
    checks++;
    if (nreq != 2 * NBITS) begin
      failures++;
      $display("FAIL midwin_bits got=%0d exp=%0d", nreq, 2 * NBITS);
    end
  endtask

  task automatic test_noise_mag();
    logic [7:0] exp_n;
    int         w40;
    do_reset();
    noise_mag_wr_i = 1'b1;
    noise_mag_i    = 8'h80;
    #1;
    checks++;
    if (noise_mag_o !== 8'h00) begin
      failures++;
      $display("FAIL noise_idle_same got=%h exp=00", noise_mag_o);
    end
    tick();
    noise_mag_wr_i = 1'b0;
    #1;
    checks++;
    if (noise_mag_o !== 8'h80) begin
      failures++;
      $display("FAIL noise_idle_next got=%h exp=80", noise_mag_o);
    end
    tick();
    w40 = RUN0 + 2 * DIV + $urandom_range(0, DIV - 1);
    for (int c = 0; c <= RUN0 + 3 * SYM + 3; c++) begin
      enable_i       = 1'b1;
      bit_i          = 1'($urandom_range(0, 1));
      noise_mag_wr_i = 1'b0;
      if (c == w40)                  begin noise_mag_wr_i = 1'b1; noise_mag_i = 8'h40; end
      if (c == RUN0 + SYM + 13)      begin noise_mag_wr_i = 1'b1; noise_mag_i = 8'h11; end
      if (c == RUN0 + 2 * SYM)       begin noise_mag_wr_i = 1'b1; noise_mag_i = 8'h22; end
      if (c == RUN0 + 2 * SYM + 6)   begin noise_mag_wr_i = 1'b1; noise_mag_i = 8'h33; end
      if (c == RUN0 + 2 * SYM + 7)   begin noise_mag_wr_i = 1'b1; noise_mag_i = 8'h44; end
      if (c <= RUN0 + SYM)           exp_n = 8'h80;
      else if (c <= RUN0 + 2 * SYM)  exp_n = 8'h40;
      else if (c <= RUN0 + 3 * SYM)  exp_n = 8'h11;
      else                           exp_n = 8'h44;
      #1;
      checks++;
      if (noise_mag_o !== exp_n) begin
        failures++;
        $display("FAIL noise_run c=%0d got=%h exp=%h", c, noise_mag_o, exp_n);
      end
      tick();
    end
    noise_mag_wr_i = 1'b0;
  endtask

  task automatic test_restart_drain();
    ctl_t e, o;
    int   drop, raise, dcyc, first_req;
    drop      = RUN0 + $urandom_range(1, WIN - 1);
    raise     = RUN0 + SYM + $urandom_range(0, DRN - 1);
    dcyc      = RUN0 + SYM + DRN;
    first_req = -1;
    do_reset();
    for (int c = 0; c <= dcyc + 10; c++) begin
      e        = (c <= dcyc) ? model(c, 0) : model(c - dcyc, NEVER);
      enable_i = (c < drop) || (c >= raise);
      bit_i    = 1'($urandom_range(0, 1));
      #1;
      o = observe();
      if (c > drop && first_req < 0 && bit_req_o === 1'b1) first_req = c;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL restart_ctrl c=%0d got=%b exp=%b", c, o, e);
      end
      tick();
    end
    checks++;
    if (first_req != dcyc + 1) begin
      failures++;
      $display("FAIL restart_fill got first bit_req at c=%0d exp c=%0d", first_req, dcyc + 1);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_stop();
    test_drop_mid_window();
    test_noise_mag();
    test_restart_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
